// File: rtl/dht11_sensor_emulator.sv
// DHT11 single-wire responder: detects a host start pulse and answers with the response and 40-bit frame.
// Optional DHT_EMU_ERR_INJ_EN adds err_inj, which flips checksum bit 0 of the frame being snapshotted.
`timescale 1ns/1ps
module dht11_sensor_emulator #(
  parameter int MIN_START_LOW = 1000000,
  parameter int RESP_DELAY    = 3750,
  parameter int T_RESP_LOW    = 10000,
  parameter int T_RESP_HIGH   = 10000,
  parameter int T_BIT_LOW     = 6250,
  parameter int T_ZERO        = 3250,
  parameter int T_ONE         = 8750
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         dht11_io,
  input  logic [15:0] humidity_in,
  input  logic [15:0] temperature_in,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  state
`ifdef DHT_EMU_ERR_INJ_EN
  ,
  input  logic        err_inj
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOST_LOW   = 3'd1,
    RESP_DLY   = 3'd2,
    RESP_LOW   = 3'd3,
    RESP_HIGH  = 3'd4,
    BIT_LOW    = 3'd5,
    BIT_HIGH   = 3'd6,
    END_LOW    = 3'd7
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(MIN_START_LOW, RESP_DELAY), max2(T_RESP_LOW, T_RESP_HIGH)),
                             max2(T_BIT_LOW, max2(T_ZERO, T_ONE)));
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] C_MIN   = CW'(MIN_START_LOW);
  localparam logic [CW-1:0] C_MIN1  = CW'(MIN_START_LOW - 1);
  localparam logic [CW-1:0] C_RD1   = CW'(RESP_DELAY - 1);
  localparam logic [CW-1:0] C_RL1   = CW'(T_RESP_LOW - 1);
  localparam logic [CW-1:0] C_RH1   = CW'(T_RESP_HIGH - 1);
  localparam logic [CW-1:0] C_BL1   = CW'(T_BIT_LOW - 1);
  localparam logic [CW-1:0] C_ZERO1 = CW'(T_ZERO - 1);
  localparam logic [CW-1:0] C_ONE1  = CW'(T_ONE - 1);

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt;
  logic [5:0]      bit_idx;
  logic [39:0]     sr;
  logic            io_m, io_s;
  logic            drive_low;
  logic [7:0]      csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_m <= 1'b1;
      io_s <= 1'b1;
    end else begin
      io_m <= dht11_io;
      io_s <= io_m;
    end
  end

  always_comb begin
    csum = humidity_in[15:8] + humidity_in[7:0] + temperature_in[15:8] + temperature_in[7:0];
`ifdef DHT_EMU_ERR_INJ_EN
    csum = csum ^ {7'd0, err_inj};
`endif
  end

  // The IDLE/RESP_DLY cycle that first sees io_s low is itself a low cycle, hence MIN-1 here.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:      if (!io_s) state_n = HOST_LOW;
      HOST_LOW:  if (io_s) state_n = (cnt >= C_MIN1) ? RESP_DLY : IDLE;
      RESP_DLY:  if (!io_s) state_n = HOST_LOW;
                 else if (cnt == C_RD1) state_n = RESP_LOW;
      RESP_LOW:  if (cnt == C_RL1) state_n = RESP_HIGH;
      RESP_HIGH: if (cnt == C_RH1) state_n = BIT_LOW;
      BIT_LOW:   if (cnt == C_BL1) state_n = BIT_HIGH;
      BIT_HIGH:  if (cnt == (sr[39] ? C_ONE1 : C_ZERO1))
                   state_n = (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
      END_LOW:   if (cnt == C_BL1) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q <= state_n;

      if (state_n != state_q) cnt <= '0;
      else if (state_q == HOST_LOW) begin
        if (!io_s && (cnt < C_MIN)) cnt <= cnt + 1'b1;
      end else if (state_q != IDLE) cnt <= cnt + 1'b1;

      if (state_q == RESP_DLY && state_n == RESP_LOW) begin
        sr      <= {humidity_in, temperature_in, csum};
        bit_idx <= '0;
      end else if (state_q == BIT_HIGH && state_n != BIT_HIGH) begin
        sr      <= {sr[38:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end

      // Outputs decoded from the next state so they switch on the transition edge.
      drive_low  <= (state_n == RESP_LOW) || (state_n == BIT_LOW) || (state_n == END_LOW);
      busy       <= (state_n != IDLE) && (state_n != HOST_LOW);
      frame_done <= (state_q == END_LOW) && (state_n == IDLE);
    end
  end

  assign dht11_io = drive_low ? 1'b0 : 1'bz;
  assign state    = state_q;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Self-checking bench for dht11_sensor_emulator: drives host start pulses, decodes the bus
// waveform and compares it against a frame model built from the sampled inputs.
`timescale 1ns/1ps
module tb_dht11_sensor_emulator;

  localparam int MIN_START_LOW = 200;
  localparam int RESP_DELAY    = 30;
  localparam int T_RESP_LOW    = 80;
  localparam int T_RESP_HIGH   = 80;
  localparam int T_BIT_LOW     = 50;
  localparam int T_ZERO        = 26;
  localparam int T_ONE         = 70;
  localparam int BOUND         = 2000;

  logic        clk;
  logic        rst_n;
  logic        host_low;
  logic [15:0] humidity_in;
  logic [15:0] temperature_in;
  logic        busy;
  logic        frame_done;
  logic [2:0]  state;
  logic        err_bit;
  wire         dht11_io;
`ifdef DHT_EMU_ERR_INJ_EN
  logic        err_inj;
`endif

  int n_checks;
  int n_err;
  int done_cnt;

  assign dht11_io = host_low ? 1'b0 : 1'bz;
  pullup (dht11_io);

  dht11_sensor_emulator #(
    .MIN_START_LOW (MIN_START_LOW),
    .RESP_DELAY    (RESP_DELAY),
    .T_RESP_LOW    (T_RESP_LOW),
    .T_RESP_HIGH   (T_RESP_HIGH),
    .T_BIT_LOW     (T_BIT_LOW),
    .T_ZERO        (T_ZERO),
    .T_ONE         (T_ONE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dht11_io       (dht11_io),
    .humidity_in    (humidity_in),
    .temperature_in (temperature_in),
    .busy           (busy),
    .frame_done     (frame_done),
    .state          (state)
`ifdef DHT_EMU_ERR_INJ_EN
    ,
    .err_inj        (err_inj)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic bus_low();
    return dht11_io === 1'b0;
  endfunction

  // Reference frame: four data bytes then their sum modulo 256 (optionally with bit 0 flipped).
  function automatic logic [39:0] model_frame(input int h, input int t, input int err);
    int sum;
    sum = ((h / 256) + (h % 256) + (t / 256) + (t % 256)) % 256;
    if (err != 0) sum = sum ^ 1;
    return {h[15:0], t[15:0], sum[7:0]};
  endfunction

  task automatic host_start(input int n);
    @(negedge clk);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
    #1;
  endtask

  // Length in negedge samples of the current bus level; returns at the first opposite sample.
  task automatic run_len(output int len);
    logic lv;
    lv  = bus_low();
    len = 0;
    while (bus_low() == lv && len < BOUND) begin
      len++;
      @(negedge clk);
    end
  endtask

  // mode 0: normal; 1: change humidity during response-high; 2: reset during bit 20 high.
  task automatic receive_frame(input logic [39:0] exp_frame, input int mode);
    int g, len, d0;
    logic [39:0] rx;
    d0 = done_cnt;
    g  = 0;
    rx = '0;
    while (!bus_low() && g < BOUND) begin
      @(negedge clk);
      g++;
    end
    check("resp_gap", g, RESP_DELAY + 3);
    check("busy_in_frame", busy, 1'b1);
    run_len(len);
    check("resp_low", len, T_RESP_LOW);
    if (mode == 1) humidity_in = 16'h4000;
    run_len(len);
    check("resp_high", len, T_RESP_HIGH);
    for (int i = 0; i < 40; i++) begin
      run_len(len);
      check("bit_low", len, T_BIT_LOW);
      if (mode == 2 && i == 20) begin
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_bus_released", bus_low(), 1'b0);
        check("rst_state", state, 3'd0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle_state", state, 3'd0);
        return;
      end
      run_len(len);
      check("bit_high", len, exp_frame[39-i] ? T_ONE : T_ZERO);
      rx = {rx[38:0], (len > (T_ZERO + T_ONE) / 2)};
    end
    run_len(len);
    check("end_low", len, T_BIT_LOW);
    check("done_pulse", frame_done, 1'b1);
    check("done_state", state, 3'd0);
    check("done_busy", busy, 1'b0);
    for (int b = 0; b < 5; b++)
      check("frame_byte", rx[39-8*b -: 8], exp_frame[39-8*b -: 8]);
    @(negedge clk);
    check("done_one_cycle", frame_done, 1'b0);
    check("done_count", done_cnt - d0, 1);
  endtask

  task automatic expect_reject(input int n);
    int lows, busys;
    host_start(n);
    lows  = 0;
    busys = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus_low()) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("reject_bus_driven", lows, 0);
    check("reject_busy", busys, 0);
    check("reject_state", state, 3'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_err          = 0;
    done_cnt       = 0;
    host_low       = 1'b0;
    humidity_in    = 16'h0;
    temperature_in = 16'h0;
    err_bit        = 1'b0;
`ifdef DHT_EMU_ERR_INJ_EN
    err_inj        = 1'b0;
`endif
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", state, 3'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", frame_done, 1'b0);
    check("reset_bus", bus_low(), 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    humidity_in = 16'h3700; temperature_in = 16'h1805;
    host_start(450);
    receive_frame(model_frame(32'h3700, 32'h1805, 0), 0);
    repeat (20) @(negedge clk);

    expect_reject(100);
    expect_reject(MIN_START_LOW - 1);

    humidity_in = 16'hFFFF; temperature_in = 16'hFFFF;
    host_start(MIN_START_LOW);
    receive_frame(model_frame(32'hFFFF, 32'hFFFF, 0), 0);
    repeat (20) @(negedge clk);

    humidity_in = 16'h0000; temperature_in = 16'h0000;
    host_start(300);
    receive_frame(model_frame(0, 0, 0), 0);
    repeat (20) @(negedge clk);

    humidity_in = 16'h3700; temperature_in = 16'h1805;
    host_start(300);
    receive_frame(model_frame(32'h3700, 32'h1805, 0), 2);
    host_start(300);
    receive_frame(model_frame(32'h3700, 32'h1805, 0), 0);
    repeat (20) @(negedge clk);

    host_start(300);
    receive_frame(model_frame(32'h3700, 32'h1805, 0), 1);
    humidity_in = 16'h3700;
    repeat (20) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      int h, t;
      h = int'($urandom_range(0, 65535));
      t = int'($urandom_range(0, 65535));
      humidity_in = h[15:0]; temperature_in = t[15:0];
      host_start(int'($urandom_range(MIN_START_LOW, MIN_START_LOW + 150)));
      receive_frame(model_frame(h, t, 0), 0);
      repeat (20) @(negedge clk);
    end

`ifdef DHT_EMU_ERR_INJ_EN
    err_inj = 1'b1;
    humidity_in = 16'h3700; temperature_in = 16'h1805;
    host_start(450);
    receive_frame(model_frame(32'h3700, 32'h1805, 1), 0);
    err_inj = 1'b0;
    repeat (20) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
